// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 opcode, bubble and NoOp constants for the IF/ID stage
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] NOOP_BUBBLE = 2'b01;
  localparam logic [1:0] NOOP_NONE   = 2'b00;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Only R-type, store and branch read rs2; I-type shifts carry shamt in that field.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/if_id_hazard_stage_if.sv
// rtl/if_id_hazard_stage_if.sv - IF/ID stage bus; StallCnt_o present with IF_ID_STALL_CNT_EN
interface if_id_hazard_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] PC_i;
  logic [XLEN-1:0] Instr_i;
  logic            Flush_i;
  logic            ID_EX_MemRead_i;
  logic [4:0]      ID_EX_Rd_i;

  logic [XLEN-1:0] PC_o;
  logic [XLEN-1:0] Instr_o;
  logic [6:0]      Op_o;
  logic [4:0]      Rs1_o;
  logic [4:0]      Rs2_o;
  logic [4:0]      Rd_o;
  logic [1:0]      NoOp_o;
  logic            Stall_o;
  logic            PCWrite_o;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0]     StallCnt_o;
`endif

  // Fetch/EX side driving the stage
  modport master (
`ifdef IF_ID_STALL_CNT_EN
    input  StallCnt_o,
`endif
    output PC_i, Instr_i, Flush_i, ID_EX_MemRead_i, ID_EX_Rd_i,
    input  PC_o, Instr_o, Op_o, Rs1_o, Rs2_o, Rd_o, NoOp_o, Stall_o, PCWrite_o
  );

  // The IF/ID stage itself
  modport slave (
`ifdef IF_ID_STALL_CNT_EN
    output StallCnt_o,
`endif
    input  PC_i, Instr_i, Flush_i, ID_EX_MemRead_i, ID_EX_Rd_i,
    output PC_o, Instr_o, Op_o, Rs1_o, Rs2_o, Rd_o, NoOp_o, Stall_o, PCWrite_o
  );

endinterface

// File: rtl/if_id_hazard_stage_load_use_detect.sv
// rtl/if_id_hazard_stage_load_use_detect.sv - combinational load-use hazard detector
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_stall
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // rs1 is compared for every opcode; rs2 only where the instruction really reads it
  always_comb begin
    w_rs1_hit = (i_ex_rd == i_rs1);
    w_rs2_hit = uses_rs2(i_op) && (i_ex_rd == i_rs2);
    o_stall   = i_valid && i_ex_memread && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
  end

endmodule

// File: rtl/if_id_hazard_stage.sv
// rtl/if_id_hazard_stage.sv - IF/ID pipeline register with load-use stall and branch flush; IF_ID_STALL_CNT_EN adds a stall counter
module if_id_hazard_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  if_id_hazard_stage_if.slave  bus
);
  import riscv_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;
  logic            w_stall;

  // Flush beats stall; a stall freezes the whole register including valid
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (bus.Flush_i) begin
      r_pc    <= bus.PC_i;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!w_stall) begin
      r_pc    <= bus.PC_i;
      r_instr <= bus.Instr_i;
      r_valid <= 1'b1;
    end
  end

  load_use_detect u_detect (
    .i_op         (r_instr[6:0]),
    .i_rs1        (r_instr[19:15]),
    .i_rs2        (r_instr[24:20]),
    .i_valid      (r_valid),
    .i_ex_memread (bus.ID_EX_MemRead_i),
    .i_ex_rd      (bus.ID_EX_Rd_i),
    .o_stall      (w_stall)
  );

  assign bus.PC_o      = r_pc;
  assign bus.Instr_o   = r_instr;
  assign bus.Op_o      = r_instr[6:0];
  assign bus.Rs1_o     = r_instr[19:15];
  assign bus.Rs2_o     = r_instr[24:20];
  assign bus.Rd_o      = r_instr[11:7];
  assign bus.Stall_o   = w_stall;
  assign bus.PCWrite_o = ~w_stall;
  assign bus.NoOp_o    = (w_stall || !r_valid) ? NOOP_BUBBLE : NOOP_NONE;

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count stalled cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.StallCnt_o = r_stall_cnt;
`endif

endmodule
